// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared states, default sizes and credit width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
  localparam int NUM_REQ = 4;
  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 8;
  function automatic int cred_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick starting at ptr and wrapping modulo num_req
module rr_arbiter #(
  parameter int num_req = 4,
  localparam int PW = num_req > 1 ? $clog2(num_req) : 1
) (
  input  logic [num_req-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               enable,
  output logic [num_req-1:0] gnt
);
  logic          w_found;
  logic [PW-1:0] w_idx;
  always_comb begin
    gnt = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int k = 0; k < num_req; k++) begin
      w_idx = PW'((int'(ptr) + k) % num_req);
      if (enable && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fall-through read data
module sync_fifo #(
  parameter int depth = 8,
  parameter int data_width = 32,
  localparam int AW = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  logic [data_width-1:0] r_mem [depth];
  logic [AW-1:0]         r_wp, r_rp;
  logic [AW:0]           r_cnt;
  logic                  w_wr, w_rd;
  assign full = r_cnt == (AW+1)'(depth);
  assign empty = r_cnt == '0;
  assign w_wr = cs && wr_en && !full;
  assign w_rd = rd_en && !empty;
  assign data_out = r_mem[r_rp];
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp == AW'(depth - 1) ? '0 : r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp == AW'(depth - 1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: credit-guarded round-robin arbitration of several writers onto one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int num_req = NUM_REQ,
  parameter int data_width = DATA_WIDTH,
  parameter int fifo_depth = FIFO_DEPTH,
  localparam int GW = num_req > 1 ? $clog2(num_req) : 1,
  localparam int CW = cred_w(fifo_depth)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            req_ready,
  input  logic                          rd_pop,
  input  logic                          fifo_full,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic [data_width-1:0]         fifo_data_in,
  output logic [GW-1:0]                 grant_id,
  output logic [CW-1:0]                 credits
);
  localparam logic [CW-1:0] FULL_CRED = CW'(fifo_depth);
  state_t                r_state;
  logic [GW-1:0]         r_ptr, r_grant_id, w_win;
  logic [CW-1:0]         r_credits, w_cred_nxt;
  logic                  r_cs, r_wr_en, w_en, w_xfer;
  logic [data_width-1:0] r_data;
  logic [num_req-1:0]    w_gnt;
  assign w_en = !rst && r_state == ACTIVE && r_credits != '0 && !fifo_full;
  rr_arbiter #(.num_req(num_req)) u_rr (
    .req(req_valid),
    .ptr(r_ptr),
    .enable(w_en),
    .gnt(w_gnt)
  );
  assign req_ready = w_gnt;
  assign w_xfer = |w_gnt;
  always_comb begin
    w_win = '0;
    for (int i = 0; i < num_req; i++)
      if (w_gnt[i]) w_win = GW'(i);
  end
  // a pop arriving while every slot is already free would overcount, so it is dropped
  assign w_cred_nxt = (w_xfer && !rd_pop) ? r_credits - 1'b1 :
                      (rd_pop && !w_xfer && r_credits != FULL_CRED) ? r_credits + 1'b1 : r_credits;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_credits <= FULL_CRED;
      r_grant_id <= '0;
      r_cs <= 1'b0;
      r_wr_en <= 1'b0;
      r_data <= '0;
    end else begin
      r_credits <= w_cred_nxt;
      r_cs <= w_xfer;
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_data <= req_data[w_win*data_width +: data_width];
        r_grant_id <= w_win;
        r_ptr <= w_win == GW'(num_req - 1) ? '0 : w_win + 1'b1;
      end
      case (r_state)
        IDLE:    r_state <= ACTIVE;
        ACTIVE:  if (w_cred_nxt == '0 || fifo_full) r_state <= STALL;
        STALL:   if (r_credits != '0 && !fifo_full) r_state <= ACTIVE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign fifo_cs = r_cs;
  assign fifo_wr_en = r_wr_en;
  assign fifo_data_in = r_data;
  assign grant_id = r_grant_id;
  assign credits = r_credits;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of the arbiter driving a sync_fifo, including FIFO output order
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         rd_pop = 1'b0;
  logic         fifo_full, fifo_empty, fifo_cs, fifo_wr_en;
  logic [31:0]  fifo_data_in, fifo_dout;
  logic [1:0]   grant_id;
  logic [3:0]   credits;
  int           n_vec = 0;
  int           n_err = 0;
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.num_req(4), .data_width(32), .fifo_depth(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rd_pop(rd_pop), .fifo_full(fifo_full), .fifo_cs(fifo_cs), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .credits(credits)
  );
  sync_fifo #(.depth(8), .data_width(32)) u_fifo (
    .clk(clk), .rst(rst), .cs(fifo_cs), .wr_en(fifo_wr_en), .rd_en(rd_pop),
    .data_in(fifo_data_in), .data_out(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_d(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask
  task automatic wr_chk(input string tag, input logic [31:0] d, input logic [1:0] g, input logic [3:0] c);
    chk({tag, "_wr"}, 32'(fifo_wr_en), 32'd1);
    chk({tag, "_cs"}, 32'(fifo_cs), 32'd1);
    chk({tag, "_data"}, fifo_data_in, d);
    chk({tag, "_gid"}, 32'(grant_id), 32'(g));
    chk({tag, "_cred"}, 32'(credits), 32'(c));
  endtask
  initial begin
    tick;
    tick;
    chk("rst_cred", 32'(credits), 32'd8);
    chk("rst_wr", 32'(fifo_wr_en), 32'd0);
    chk("rst_cs", 32'(fifo_cs), 32'd0);
    chk("rst_data", fifo_data_in, 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    tick;
    chk("idle_to_active", 32'(dut.r_state), 32'(ACTIVE));
    chk("drop_cred", 32'(credits), 32'd8);
    req_valid = 4'b0001;
    set_d(0, 32'd1);
    #1;
    chk("s1_ready0", 32'(req_ready), 32'b0001);
    tick;
    wr_chk("s1_w0", 32'd1, 2'd0, 4'd7);
    set_d(0, 32'd10);
    tick;
    wr_chk("s1_w1", 32'd10, 2'd0, 4'd6);
    set_d(0, 32'd100);
    tick;
    wr_chk("s1_w2", 32'd100, 2'd0, 4'd5);
    req_valid = 4'b0000;
    tick;
    chk("s1_wr_off", 32'(fifo_wr_en), 32'd0);
    chk("s1_cs_off", 32'(fifo_cs), 32'd0);
    chk("s1_hold", fifo_data_in, 32'd100);
    chk("s1_cred", 32'(credits), 32'd5);
    rd_pop = 1'b1;
    #1;
    chk("s1_rd0", fifo_dout, 32'd1);
    tick;
    chk("s1_rd1", fifo_dout, 32'd10);
    tick;
    chk("s1_rd2", fifo_dout, 32'd100);
    tick;
    rd_pop = 1'b0;
    chk("s1_cred_back", 32'(credits), 32'd8);
    chk("s1_ptr", 32'(dut.r_ptr), 32'd1);
    rst = 1'b1;
    tick;
    chk("rst2_ptr", 32'(dut.r_ptr), 32'd0);
    rst = 1'b0;
    tick;
    rd_pop = 1'b1;
    #1;
    chk("s6_ready", 32'(req_ready), 32'd0);
    tick;
    chk("s6_cred", 32'(credits), 32'd8);
    chk("s6_wr", 32'(fifo_wr_en), 32'd0);
    rd_pop = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) set_d(i, 32'(16 * i + k));
      #1;
      chk("s2_ready", 32'(req_ready), 32'(1 << (k % 4)));
      tick;
      wr_chk("s2_w", 32'(16 * (k % 4) + k), 2'(k % 4), 4'(7 - k));
    end
    for (int i = 0; i < 4; i++) set_d(i, 32'(16 * i + 8));
    #1;
    chk("s2_state", 32'(dut.r_state), 32'(STALL));
    chk("s2_ready_stall", 32'(req_ready), 32'd0);
    tick;
    chk("s2_wr_off", 32'(fifo_wr_en), 32'd0);
    chk("s2_cred0", 32'(credits), 32'd0);
    chk("s2_full", 32'(fifo_full), 32'd1);
    rd_pop = 1'b1;
    #1;
    chk("s3_rd", fifo_dout, 32'h00);
    tick;
    rd_pop = 1'b0;
    chk("s3_cred1", 32'(credits), 32'd1);
    chk("s3_ready_stall", 32'(req_ready), 32'd0);
    tick;
    chk("s3_active", 32'(dut.r_state), 32'(ACTIVE));
    chk("s3_ready", 32'(req_ready), 32'b0001);
    tick;
    wr_chk("s3_w", 32'h08, 2'd0, 4'd0);
    chk("s3_stall", 32'(dut.r_state), 32'(STALL));
    chk("s3_ready_off", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    tick;
    chk("s3_wr_off", 32'(fifo_wr_en), 32'd0);
    rd_pop = 1'b1;
    #1;
    chk("s4_rd0", fifo_dout, 32'h11);
    tick;
    chk("s4_rd1", fifo_dout, 32'h22);
    tick;
    chk("s4_rd2", fifo_dout, 32'h33);
    tick;
    chk("s4_cred3", 32'(credits), 32'd3);
    req_valid = 4'b0010;
    set_d(1, 32'hAB);
    #1;
    chk("s4_rd3", fifo_dout, 32'h04);
    chk("s4_ready", 32'(req_ready), 32'b0010);
    tick;
    wr_chk("s4_w", 32'hAB, 2'd1, 4'd3);
    req_valid = 4'b0000;
    #1;
    chk("s5_rd", fifo_dout, 32'h15);
    tick;
    rd_pop = 1'b0;
    chk("s5_cred4", 32'(credits), 32'd4);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_d(i, 32'(32'h40 + i));
    #1;
    chk("s5_ready_pre", 32'(req_ready), 32'b0100);
    rst = 1'b1;
    #1;
    chk("s5_ready_rst", 32'(req_ready), 32'd0);
    tick;
    chk("s5_wr", 32'(fifo_wr_en), 32'd0);
    chk("s5_cs", 32'(fifo_cs), 32'd0);
    chk("s5_cred", 32'(credits), 32'd8);
    chk("s5_ptr", 32'(dut.r_ptr), 32'd0);
    chk("s5_state", 32'(dut.r_state), 32'(IDLE));
    chk("s5_data", fifo_data_in, 32'd0);
    rst = 1'b0;
    #1;
    chk("s5_idle_ready", 32'(req_ready), 32'd0);
    tick;
    chk("s5_ready", 32'(req_ready), 32'b0001);
    tick;
    wr_chk("s5_w", 32'h40, 2'd0, 4'd7);
    req_valid = 4'b0000;
    tick;
    rd_pop = 1'b1;
    #1;
    chk("s5_empty", 32'(fifo_empty), 32'd0);
    chk("s5_rd", fifo_dout, 32'h40);
    tick;
    rd_pop = 1'b0;
    chk("s5_cred_end", 32'(credits), 32'd8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter num_req, default 4, number of write requesters sharing one sync_fifo write port.
REQ-002 Parameter data_width, default 32, data word width; matches the FIFO data_width.
REQ-003 Parameter fifo_depth, default 8, FIFO capacity in words; sets the credit counter reset value.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  num_req  per-requester write request.
- req_data  in  num_req*data_width  per-requester data; slice i belongs to requester i.
- req_ready  out  num_req  one-hot grant; transfer when req_valid[i] & req_ready[i].
- rd_pop  in  1  pulse: consumer popped one word from the FIFO this cycle.
- fifo_full  in  1  FIFO full flag, used as a secondary guard.
- fifo_cs  out  1  FIFO chip select.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data_in  out  data_width  FIFO write data.
- grant_id  out  clog2(num_req)  index of the last granted requester, registered.
- credits  out  clog2(fifo_depth)+1  free FIFO slots as tracked by the arbiter.

Function
REQ-006 req_ready SHALL be combinational from the registered state and the current req_valid, with at most one bit set.
REQ-007 A grant SHALL be issued only when state is ACTIVE, credits > 0, and fifo_full = 0.
REQ-008 Round-robin: search starts at requester ptr, wraps modulo num_req, and selects the first requester with req_valid set.
REQ-009 On a transfer, ptr SHALL become (winner+1) mod num_req at the next edge; with no transfer, ptr holds.
REQ-010 Write latency SHALL be 1 cycle:
- The edge after a transfer registers fifo_cs=1, fifo_wr_en=1, fifo_data_in=winner data, grant_id=winner.
- With no transfer, fifo_wr_en=0 and fifo_cs=0 at the next edge, and fifo_data_in holds its value.
REQ-011 Credit update per edge:
- transfer only: credits-1.
- rd_pop only: credits+1.
- both, or neither: unchanged.
REQ-012 credits SHALL saturate at fifo_depth.
- rd_pop while credits = fifo_depth is ignored.
- credits never goes below 0, because no grant is issued at 0.
REQ-013 The state machine SHALL have three states: IDLE, ACTIVE, STALL.
- IDLE -> ACTIVE one cycle after reset is released.
- ACTIVE -> STALL when the next credits value is 0, or fifo_full = 1.
- STALL -> ACTIVE when credits > 0 and fifo_full = 0.
- No grants are issued in IDLE or STALL.
REQ-014 A requester holding req_valid SHALL be granted within num_req grant cycles (no starvation).
REQ-015 Dropping req_valid without a transfer SHALL be allowed and SHALL leave no side effect.
REQ-016 At most one FIFO write SHALL be issued per cycle.
- fifo_wr_en SHALL never assert when the credits value before the write was 0.

Reset
REQ-017 On an rst=1 edge the block SHALL set:
- state = IDLE, ptr = 0, credits = fifo_depth, grant_id = 0.
- fifo_cs = 0, fifo_wr_en = 0, fifo_data_in = 0.
REQ-018 Reset asserted mid-operation SHALL discard any in-flight grant; the write registered on that edge SHALL be suppressed.
REQ-019 req_ready SHALL be all-zero while rst = 1 and in the first cycle after reset (IDLE).

Structure
REQ-020 A shared package fifo_arb_pkg SHALL hold:
- the state enum (IDLE, ACTIVE, STALL);
- default constants NUM_REQ=4, DATA_WIDTH=32, FIFO_DEPTH=8;
- the credit-width function.
REQ-021 The round-robin search SHALL be one sub-module, rr_arbiter (inputs req, ptr, enable; output one-hot gnt), instantiated once.

Verification
REQ-022 The bench SHALL instantiate fifo_wr_arbiter together with sync_fifo (fifo_depth=8, data_width=32) and check data order at the FIFO output.
REQ-023 Directed scenarios:
- Single requester: req0 sends 1, 10, 100 back-to-back -> fifo_wr_en for 3 cycles, each one cycle after its transfer; FIFO reads return 1, 10, 100; credits = 5.
- All four valid continuously, data = 0x10*i plus sequence number -> grant order 0,1,2,3,0,1,2,3; credits reach 0 after 8 writes; state STALL; req_ready = 0.
- Full FIFO, one rd_pop -> credits = 1; exactly one grant, to the next requester in round-robin order; STALL again.
- Transfer and rd_pop in the same cycle with credits = 3 -> credits stays 3.
- rst pulsed while all requesters are valid and credits = 4 -> next edge: fifo_wr_en = 0, credits = 8, ptr = 0; the first grant after IDLE goes to req0.
- rd_pop with credits = 8 -> credits stays 8; no grant issued without req_valid.
